// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: turns CPU byte/half/word load-store requests into cycles on a
// word-wide synchronous RAM. Sub-word stores read the word, merge the new lane(s)
// and write it back; loads pick the addressed lane and sign/zero-extend it.
module ram_access_ctrl #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_CAPT  = 3'd2,
        WR       = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t              state;
    state_t              state_nxt;

    logic                we_q;
    logic [1:0]          size_q;
    logic                sign_ext_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         word_q;
    logic                err_q;

    logic                accept;
    logic                illegal;
    logic [31:0]         merged;
    logic [31:0]         load_val;
    logic [7:0]          load_byte;
    logic [15:0]         load_half;

    // Address bits above the RAM word index are dropped, so accesses wrap.
    logic                unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign accept  = (state == IDLE) && req;
    assign illegal = (size == 2'b11)
                   || ((size == SZ_HALF) && addr[0])
                   || ((size == SZ_WORD) && (addr[1:0] != 2'b00));

    // Request capture: operands are latched once at accept and held for the whole operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            sign_ext_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else if (accept) begin
            we_q       <= we;
            size_q     <= size;
            sign_ext_q <= sign_ext;
            addr_q     <= addr[ADDR_W+1:0];
            wdata_q    <= wdata;
            err_q      <= illegal;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: illegal requests skip straight to DONE without touching the RAM.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (illegal) begin
                        state_nxt = DONE;
                    end else if (we && (size == SZ_WORD)) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: state_nxt = RD_CAPT;
            RD_CAPT:  state_nxt = we_q ? WR : DONE;
            WR:       state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Lane extraction straight from the RAM output so the result is ready at the RD_CAPT edge.
    always_comb begin
        load_byte = 8'd0;
        load_half = 16'd0;
        load_val  = ram_rdata;
        case (addr_q[1:0])
            2'd0:    load_byte = ram_rdata[7:0];
            2'd1:    load_byte = ram_rdata[15:8];
            2'd2:    load_byte = ram_rdata[23:16];
            default: load_byte = ram_rdata[31:24];
        endcase
        load_half = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_val = {{24{sign_ext_q & load_byte[7]}}, load_byte};
            SZ_HALF: load_val = {{16{sign_ext_q & load_half[15]}}, load_half};
            default: load_val = ram_rdata;
        endcase
    end

    // Read capture: ram_rdata is only valid while ram_ena is high, so both the raw word and the load result are taken at the end of RD_CAPT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= 32'd0;
            rdata  <= 32'd0;
        end else if (state == RD_CAPT) begin
            word_q <= ram_rdata;
            if (!we_q) begin
                rdata <= load_val;
            end
        end
    end

    // Store merge: sub-word stores overwrite only the addressed lane(s) of the word just read.
    always_comb begin
        merged = word_q;
        case (size_q)
            SZ_BYTE: begin
                case (addr_q[1:0])
                    2'd0:    merged[7:0]   = wdata_q[7:0];
                    2'd1:    merged[15:8]  = wdata_q[7:0];
                    2'd2:    merged[23:16] = wdata_q[7:0];
                    default: merged[31:24] = wdata_q[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_q[1]) begin
                    merged[31:16] = wdata_q[15:0];
                end else begin
                    merged[15:0]  = wdata_q[15:0];
                end
            end
            default: merged = wdata_q;
        endcase
    end

    // Output decode: everything the CPU and RAM see is a function of the current state.
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        err       = (state == DONE) && err_q;
        ram_ena   = (state == RD_ISSUE) || (state == RD_CAPT) || (state == WR);
        ram_wena  = (state == WR);
        ram_wdata = (state == WR) ? merged : 32'd0;
        ram_addr  = addr_q[ADDR_W+1:2];
    end

endmodule
